// File: rtl/board_pkg.sv
// Shared types and sizes for the Minesweeper board memory.
// Contents: address/data widths, cell count and the Wishbone responder state type.
package board_pkg;

  localparam int unsigned BOARD_ADDR_W = 8;
  localparam int unsigned BOARD_DATA_W = 8;
  localparam int unsigned BOARD_CELLS  = 256;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACK
  } wb_slv_state_t;

endpackage

// File: rtl/board_ram.sv
// 256x8 simple dual-port board RAM.
// Port A: synchronous read/write. a_rdat_o only updates on a read, so it holds between reads.
// Port B: synchronous read-only. On an address collision with a port A write it returns the
//         old contents (read-before-write).
// Ports: clk_i, rst_ni (sync, clears read registers), a_en_i, a_we_i, a_adr_i, a_wdat_i,
//        a_rdat_o, b_adr_i, b_rdat_o.
module board_ram
  import board_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_en_i,
  input  logic                    a_we_i,
  input  logic [BOARD_ADDR_W-1:0] a_adr_i,
  input  logic [BOARD_DATA_W-1:0] a_wdat_i,
  output logic [BOARD_DATA_W-1:0] a_rdat_o,
  input  logic [BOARD_ADDR_W-1:0] b_adr_i,
  output logic [BOARD_DATA_W-1:0] b_rdat_o
);

  logic [BOARD_DATA_W-1:0] mem_q [BOARD_CELLS];

  // Storage array carries no reset; callers gate a_en_i with reset.
  always_ff @(posedge clk_i) begin
    if (a_en_i && a_we_i) begin
      mem_q[a_adr_i] <= a_wdat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_rdat_o <= '0;
      b_rdat_o <= '0;
    end else begin
      if (a_en_i && !a_we_i) begin
        a_rdat_o <= mem_q[a_adr_i];
      end
      b_rdat_o <= mem_q[b_adr_i];
    end
  end

endmodule

// File: rtl/board_mem_wb_slave.sv
// Wishbone responder for the 16x16 Minesweeper board (one byte per cell, 0x00-0xFF), plus a
// fixed-latency read-only display port for the VGA renderer.
// Ports: CLK_I, RST_I (sync, active low); Wishbone slave modport adr_o, dat_o, we_o, stb_o,
//        cyc_o (inputs) and dat_i, ack_i, stall_i (outputs); display disp_adr in, disp_dat out.
// Signal names follow the board interface, so *_o names are inputs here.
// Build option BOARD_MEM_INIT_CLEAR_EN: after reset, sweep INIT_VAL into every cell while
// stalling the bus for DEPTH cycles. Without it, RAM contents after reset are undefined.
module board_mem_wb_slave
  import board_pkg::*;
#(
  parameter int unsigned             DEPTH    = BOARD_CELLS,
  parameter logic [BOARD_DATA_W-1:0] INIT_VAL = 8'h00
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [BOARD_ADDR_W-1:0] adr_o,
  input  logic [BOARD_DATA_W-1:0] dat_o,
  input  logic                    we_o,
  input  logic                    stb_o,
  input  logic                    cyc_o,
  output logic [BOARD_DATA_W-1:0] dat_i,
  output logic                    ack_i,
  output logic                    stall_i,
  input  logic [BOARD_ADDR_W-1:0] disp_adr,
  output logic [BOARD_DATA_W-1:0] disp_dat
);

  if (DEPTH != BOARD_CELLS) begin : g_bad_depth
    $error("board_mem_wb_slave: DEPTH must be 256");
  end

  wb_slv_state_t           state_q;
  logic                    accept;
  logic                    sweep_we;
  logic [BOARD_ADDR_W-1:0] sweep_adr;
  logic                    ram_en;
  logic                    ram_we;
  logic [BOARD_ADDR_W-1:0] ram_adr;
  logic [BOARD_DATA_W-1:0] ram_wdat;

  assign accept = cyc_o & stb_o & ~stall_i;

`ifdef BOARD_MEM_INIT_CLEAR_EN
  logic [BOARD_ADDR_W-1:0] sweep_q;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          sweep_q <= sweep_q + 8'd1;
          // Sweep ends on the last address, not on counter wrap.
          if (sweep_q == 8'(DEPTH - 1)) state_q <= IDLE;
        end
        IDLE:    if (accept) state_q <= ACK;
        ACK:     if (!accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_i   = (state_q == INIT);
  assign sweep_we  = stall_i;
  assign sweep_adr = sweep_q;
`else
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_q <= ACK;
        ACK:     if (!accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_i   = 1'b0;
  assign sweep_we  = 1'b0;
  assign sweep_adr = '0;
`endif

  // Ack is suppressed (not delayed) if the master drops cyc_o while it is pending.
  assign ack_i = (state_q == ACK) & cyc_o;

  // Reset has priority: a write presented in a reset cycle is discarded.
  assign ram_en   = RST_I & (sweep_we | accept);
  assign ram_we   = sweep_we | we_o;
  assign ram_adr  = sweep_we ? sweep_adr : adr_o;
  assign ram_wdat = sweep_we ? INIT_VAL : dat_o;

  board_ram u_ram (
    .clk_i    (CLK_I),
    .rst_ni   (RST_I),
    .a_en_i   (ram_en),
    .a_we_i   (ram_we),
    .a_adr_i  (ram_adr),
    .a_wdat_i (ram_wdat),
    .a_rdat_o (dat_i),
    .b_adr_i  (disp_adr),
    .b_rdat_o (disp_dat)
  );

endmodule
